// File: rtl/text_pkg.sv
// Shared definitions for the text overlay: glyph cell geometry, FSM states
// and helpers for the blank code and the window bounds.
package text_pkg;
    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        CLR_LINE = 2'd2
    } state_t;

    // The blank cell is the all-ones character code
    function automatic int blank_code(input int code_w);
        return int'((32'd1 << code_w) - 32'd1);
    endfunction

    function automatic int win_x_end(input int x0, input int cols);
        return x0 + CHAR_W * cols;
    endfunction

    function automatic int win_y_end(input int y0, input int rows);
        return y0 + CHAR_H * rows;
    endfunction
endpackage

// File: rtl/text_buf.sv
// Simple dual-port character buffer: one write port, one registered read port.
module text_buf #(
    parameter  int DEPTH = 128,
    parameter  int W     = 6,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port
    always_ff @(posedge i_clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/text_overlay.sv
// Multi-row text overlay: character buffer with cursor, backspace, clear and
// optional scrolling, plus a 3-stage render pipeline driving the red channel.
module text_overlay
    import text_pkg::*;
#(
    parameter  int COLS      = 32,
    parameter  int ROWS      = 4,
    parameter  int X0        = 192,
    parameter  int Y0        = 208,
    parameter  int CODE_W    = 6,
    parameter  int SCROLL    = 0,
    parameter  int CURSOR_EN = 1,
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_char_valid,
    input  logic [CODE_W-1:0] i_char_code,
    output logic              o_char_ready,
    input  logic              i_cmd_backspace,
    input  logic              i_cmd_clear,
    input  logic              i_video_on,
    input  logic [9:0]        i_x,
    input  logic [9:0]        i_y,
    output logic [CODE_W-1:0] o_rom_code,
    output logic [3:0]        o_rom_row,
    input  logic [7:0]        i_rom_data,
    output logic              o_vga_r,
    output logic [CW-1:0]     o_cursor_col,
    output logic [RW-1:0]     o_cursor_row,
    output logic              o_full
);
    localparam int                CELLS  = ROWS * COLS;
    localparam int                AW     = $clog2(CELLS);
    localparam int                X1     = win_x_end(X0, COLS);
    localparam int                Y1     = win_y_end(Y0, ROWS);
    localparam logic [CODE_W-1:0] BLANK  = CODE_W'(blank_code(CODE_W));
    localparam logic [RW:0]       ROWS_W = (RW+1)'(ROWS);

    // Logical rows are stored rotated by r_top so scrolling never copies data
    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] top, input logic [RW-1:0] row);
        logic [RW:0] sum;
        sum = {1'b0, top} + {1'b0, row};
        return (sum >= ROWS_W) ? RW'(sum - ROWS_W) : RW'(sum);
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow, input logic [CW-1:0] col);
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    state_t            r_state;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [RW-1:0]     r_top;
    logic              r_full;
    logic [AW-1:0]     r_cnt;
    logic              w_accept;
    logic [RW-1:0]     w_cur_prow;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [CODE_W-1:0] w_wdata;
    logic [CODE_W-1:0] w_rdata;

    assign o_char_ready = (r_state == IDLE) && !r_full && !i_cmd_clear && !i_cmd_backspace;
    assign w_accept     = i_char_valid && o_char_ready;
    assign w_cur_prow   = phys_row(r_top, r_row);

    // Buffer write port: clear sweeps, backspace blanking and character writes
    always_comb begin
        w_we    = 1'b0;
        w_waddr = cell_addr(w_cur_prow, r_col);
        w_wdata = BLANK;
        if (i_cmd_clear) begin
            w_we = 1'b0;
        end else begin
            case (r_state)
                CLR_ALL: begin
                    w_we    = 1'b1;
                    w_waddr = r_cnt;
                end
                CLR_LINE: begin
                    w_we    = 1'b1;
                    w_waddr = cell_addr(w_cur_prow, CW'(r_cnt));
                end
                IDLE: begin
                    if (i_cmd_backspace) begin
                        if (r_full) begin
                            w_we = 1'b1;
                        end else if (r_col != '0) begin
                            w_we    = 1'b1;
                            w_waddr = cell_addr(w_cur_prow, r_col - CW'(1));
                        end else begin
                            w_we = 1'b0;
                        end
                    end else if (w_accept) begin
                        w_we    = 1'b1;
                        w_wdata = i_char_code;
                    end else begin
                        w_we = 1'b0;
                    end
                end
                default: w_we = 1'b0;
            endcase
        end
    end

    // Control FSM with cursor, scroll origin and full flag
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_cmd_clear) begin
            r_state <= CLR_ALL;
            r_col   <= '0;
            r_row   <= '0;
            r_top   <= '0;
            r_full  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                CLR_ALL: begin
                    if (r_cnt == AW'(CELLS - 1)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                CLR_LINE: begin
                    if (r_cnt == AW'(COLS - 1)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                IDLE: begin
                    if (i_cmd_backspace) begin
                        // When full the cursor still sits on the last cell, which is the one erased
                        if (r_full) begin
                            r_full <= 1'b0;
                        end else if (r_col != '0) begin
                            r_col <= r_col - CW'(1);
                        end
                    end else if (w_accept) begin
                        if (r_col != CW'(COLS - 1)) begin
                            r_col <= r_col + CW'(1);
                        end else if (r_row != RW'(ROWS - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else if (SCROLL == 0) begin
                            r_full <= 1'b1;
                        end else begin
                            r_top   <= phys_row(r_top, RW'(1));
                            r_col   <= '0;
                            r_state <= CLR_LINE;
                            r_cnt   <= '0;
                        end
                    end
                end
                default: r_state <= CLR_ALL;
            endcase
        end
    end

    logic [9:0]    w_dx;
    logic [9:0]    w_dy;
    logic [CW-1:0] w_lcol;
    logic [RW-1:0] w_lrow;
    logic          w_in_win;
    logic          w_cur_hit;
    logic [AW-1:0] w_raddr;

    assign w_in_win  = i_video_on && ({1'b0, i_x} >= 11'(X0)) && ({1'b0, i_x} < 11'(X1))
                                  && ({1'b0, i_y} >= 11'(Y0)) && ({1'b0, i_y} < 11'(Y1));
    assign w_dx      = i_x - 10'(X0);
    assign w_dy      = i_y - 10'(Y0);
    assign w_lcol    = CW'(w_dx >> $clog2(CHAR_W));
    assign w_lrow    = RW'(w_dy >> $clog2(CHAR_H));
    assign w_raddr   = cell_addr(phys_row(r_top, w_lrow), w_lcol);
    assign w_cur_hit = (CURSOR_EN != 0) && w_in_win && (w_lcol == r_col) && (w_lrow == r_row)
                       && (i_y[3:0] == 4'hF);

    text_buf #(.DEPTH(CELLS), .W(CODE_W)) u_buf (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    logic       r_v1, r_cur1, r_v2, r_cur2, r_blank2, r_vga_r;
    logic [3:0] r_row1;
    logic [2:0] r_bit1, r_bit2;

    // Render pipeline: address, buffer/ROM lookup, then pixel register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_v1     <= 1'b0;
            r_cur1   <= 1'b0;
            r_row1   <= 4'd0;
            r_bit1   <= 3'd0;
            r_v2     <= 1'b0;
            r_cur2   <= 1'b0;
            r_blank2 <= 1'b0;
            r_bit2   <= 3'd0;
            r_vga_r  <= 1'b0;
        end else begin
            r_v1     <= w_in_win;
            r_cur1   <= w_cur_hit;
            r_row1   <= i_y[3:0];
            r_bit1   <= i_x[2:0];
            r_v2     <= r_v1;
            r_cur2   <= r_cur1;
            r_blank2 <= (w_rdata == BLANK);
            r_bit2   <= r_bit1;
            r_vga_r  <= (r_v2 && !r_blank2 && i_rom_data[3'd7 - r_bit2]) || r_cur2;
        end
    end

    assign o_rom_code   = w_rdata;
    assign o_rom_row    = r_row1;
    assign o_vga_r      = r_vga_r;
    assign o_cursor_col = r_col;
    assign o_cursor_row = r_row;
    assign o_full       = r_full;
endmodule
